// File: rtl/load_store_unit.sv
// Purpose : converts byte/half/word loads and stores into word-only memory reads and writes (RMW for sub-word stores).
// Latency : load done at T+2, word store done at T+2, sub-word store done at T+3 (request accepted in cycle T).
// Backpr. : busy_out high while a transaction is in flight; requests seen while busy are dropped, not queued.
// Optional: define MISALIGN_TRAP_EN to drop misaligned half/word requests and pulse misaligned_out instead.
module load_store_unit #(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid_in,
   input  logic        req_we_in,
   input  logic [1:0]  req_size_in,
   input  logic        req_signed_in,
   input  logic [31:0] req_addr_in,
   input  logic [31:0] req_wdata_in,
   output logic        busy_out,
   output logic        done_out,
   output logic [31:0] load_data_out,
   output logic        misaligned_out,
   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_writedata_out,
   output logic        mem_re_out,
   output logic        mem_we_out,
   output logic [1:0]  mem_size_out,
   input  logic [31:0] mem_readdata_in
);

`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic [1:0]  lo_q, lo_d;
   logic [15:0] wdat_q, wdat_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        mem_re_q, mem_re_d;
   logic        mem_we_q, mem_we_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        misal_q, misal_d;
   logic [31:0] load_data_q, load_data_d;
   logic        misaligned_req;

   // Bit offset of the addressed byte inside the word.
   function automatic logic [4:0] byte_base(input logic [1:0] a);
      logic [1:0] lane;
      lane = BIG_ENDIAN ? (2'd3 - a) : a;
      return {lane, 3'b000};
   endfunction

   // True when the addressed half-word sits in bits [31:16].
   function automatic logic half_hi(input logic a1);
      return BIG_ENDIAN ? ~a1 : a1;
   endfunction

   // Pull the addressed lane out of a memory word and extend it.
   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] a, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[byte_base(a) +: 8];
      h = half_hi(a[1]) ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Overlay the new sub-word store data onto the word read back from memory.
   function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] d,
                                         input logic [1:0] sz, input logic [1:0] a);
      logic [31:0] r;
      r = w;
      if (sz == 2'b00) begin
         r[byte_base(a) +: 8] = d[7:0];
      end else if (half_hi(a[1])) begin
         r[31:16] = d;
      end else begin
         r[15:0] = d;
      end
      return r;
   endfunction

   // Half requests need addr[0]==0, word requests need addr[1:0]==0; only enforced when trapping.
   assign misaligned_req = TRAP_EN &&
                           (((req_size_in == 2'b01) && req_addr_in[0]) ||
                            (req_size_in[1] && (req_addr_in[1:0] != 2'b00)));

   // Next-state and next-output logic; strobes and pulses default low so each lasts one cycle.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      sgn_d       = sgn_q;
      lo_d        = lo_q;
      wdat_d      = wdat_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      load_data_d = load_data_q;
      busy_d      = busy_q;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
      done_d      = 1'b0;
      misal_d     = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (req_valid_in) begin
               if (misaligned_req) begin
                  misal_d = 1'b1;
               end else begin
                  we_d       = req_we_in;
                  size_d     = req_size_in;
                  sgn_d      = req_signed_in;
                  lo_d       = req_addr_in[1:0];
                  wdat_d     = req_wdata_in[15:0];
                  mem_addr_d = {req_addr_in[31:2], 2'b00};
                  busy_d     = 1'b1;
                  if (req_we_in && req_size_in[1]) begin
                     mem_wdata_d = req_wdata_in;
                     mem_we_d    = 1'b1;
                     state_d     = WR;
                  end else begin
                     mem_re_d = 1'b1;
                     state_d  = RD;
                  end
               end
            end
         end
         RD: begin
            if (we_q) begin
               mem_wdata_d = merge(mem_readdata_in, wdat_q, size_q, lo_q);
               mem_we_d    = 1'b1;
               state_d     = WR;
            end else begin
               load_data_d = extract(mem_readdata_in, size_q, lo_q, sgn_q);
               done_d      = 1'b1;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         WR: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transaction in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         sgn_q       <= 1'b0;
         lo_q        <= 2'b00;
         wdat_q      <= 16'h0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         load_data_q <= 32'h0;
         busy_q      <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         done_q      <= 1'b0;
         misal_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         sgn_q       <= sgn_d;
         lo_q        <= lo_d;
         wdat_q      <= wdat_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         load_data_q <= load_data_d;
         busy_q      <= busy_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         done_q      <= done_d;
         misal_q     <= misal_d;
      end
   end

   assign busy_out          = busy_q;
   assign done_out          = done_q;
   assign load_data_out     = load_data_q;
   assign misaligned_out    = misal_q;
   assign mem_addr_out      = mem_addr_q;
   assign mem_writedata_out = mem_wdata_q;
   assign mem_re_out        = mem_re_q;
   assign mem_we_out        = mem_we_q;
   assign mem_size_out      = 2'b11;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model, expected strobes/completions queued at issue,
// popped and compared by a negedge monitor (including the cycle they must appear in).
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        busy, done, misal, mem_re, mem_we;
   logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  mem_size;

   always #5 clk = ~clk;

   load_store_unit #(.BIG_ENDIAN(1'b1)) dut (
      .clock(clk), .reset(rst),
      .req_valid_in(req_valid), .req_we_in(req_we), .req_size_in(req_size),
      .req_signed_in(req_signed), .req_addr_in(req_addr), .req_wdata_in(req_wdata),
      .busy_out(busy), .done_out(done), .load_data_out(load_data), .misaligned_out(misal),
      .mem_addr_out(mem_addr), .mem_writedata_out(mem_wdata), .mem_re_out(mem_re),
      .mem_we_out(mem_we), .mem_size_out(mem_size), .mem_readdata_in(mem_rdata)
   );

   localparam logic [31:0] A = 32'h1000_0000;
   localparam logic [31:0] B = 32'h7FFF_FFFC;
   localparam int K_LOAD = 0, K_WST = 1, K_SST = 2, K_MIS = 3, K_RDONLY = 4;

   // Small word memory: combinational read, write at the rising edge ending a write cycle.
   logic [31:0] mem [16];
   logic        pre_en = 1'b0;
   logic [31:0] pre_addr, pre_data;

   function automatic int idx(input logic [31:0] a);
      return int'({a[30], a[4:2]});
   endfunction

   assign mem_rdata = mem[idx(mem_addr)];

   always @(posedge clk) begin
      if (mem_we) mem[idx(mem_addr)] <= mem_wdata;
      else if (pre_en) mem[idx(pre_addr)] <= pre_data;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct { bit we; logic [31:0] addr; logic [31:0] data; int cyc; } strobe_t;
   typedef struct { bit is_load; logic [31:0] data; int cyc; } done_t;
   strobe_t sq[$];
   done_t   dq[$];
   int      mq[$];

   // Monitor: every strobe, completion and trap pulse must match the head of its queue.
   always @(negedge clk) begin
      if (mem_re || mem_we) begin
         check("re_we_exclusive", {31'b0, mem_re & mem_we}, 32'h0);
         check("mem_size", {30'b0, mem_size}, 32'h3);
         if (sq.size() == 0) begin
            check("unexpected_strobe", {30'b0, mem_re, mem_we}, 32'h0);
         end else begin
            strobe_t e;
            e = sq.pop_front();
            check("strobe_kind", {31'b0, mem_we}, {31'b0, e.we});
            check("strobe_cycle", 32'(cyc), 32'(e.cyc));
            check("strobe_addr", mem_addr, e.addr);
            if (e.we) check("strobe_wdata", mem_wdata, e.data);
         end
      end
      if (done) begin
         if (dq.size() == 0) begin
            check("unexpected_done", {31'b0, done}, 32'h0);
         end else begin
            done_t d;
            d = dq.pop_front();
            check("done_cycle", 32'(cyc), 32'(d.cyc));
            if (d.is_load) check("load_data", load_data, d.data);
         end
      end
      if (misal) begin
         if (mq.size() == 0) begin
            check("unexpected_misaligned", {31'b0, misal}, 32'h0);
         end else begin
            int mc;
            mc = mq.pop_front();
            check("misaligned_cycle", 32'(cyc), 32'(mc));
         end
      end
   end

   task automatic preset(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   // Drives one request for one cycle and queues the responses it must produce.
   task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int kind, input logic [31:0] exp);
      int t;
      logic [31:0] wa;
      @(negedge clk);
      t  = cyc;
      wa = {a[31:2], 2'b00};
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
      req_addr = a; req_wdata = wd;
      case (kind)
         K_LOAD: begin
            sq.push_back('{we: 1'b0, addr: wa, data: 32'h0, cyc: t + 1});
            dq.push_back('{is_load: 1'b1, data: exp, cyc: t + 2});
         end
         K_WST: begin
            sq.push_back('{we: 1'b1, addr: wa, data: wd, cyc: t + 1});
            dq.push_back('{is_load: 1'b0, data: 32'h0, cyc: t + 2});
         end
         K_SST: begin
            sq.push_back('{we: 1'b0, addr: wa, data: 32'h0, cyc: t + 1});
            sq.push_back('{we: 1'b1, addr: wa, data: exp, cyc: t + 2});
            dq.push_back('{is_load: 1'b0, data: 32'h0, cyc: t + 3});
         end
         K_MIS:    mq.push_back(t + 1);
         default:  sq.push_back('{we: 1'b0, addr: wa, data: 32'h0, cyc: t + 1});
      endcase
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Bounded wait for all expected events, then confirm nothing is left outstanding.
   task automatic drain();
      int n;
      n = 0;
      while ((sq.size() + dq.size() + mq.size()) != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      #1;
      check("events_pending", 32'(sq.size() + dq.size() + mq.size()), 32'h0);
      sq.delete(); dq.delete(); mq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; pre_addr = 32'h0; pre_data = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      check("rst_re", {31'b0, mem_re}, 32'h0);
      check("rst_we", {31'b0, mem_we}, 32'h0);
      check("rst_size", {30'b0, mem_size}, 32'h3);
      check("rst_load_data", load_data, 32'h0);
      check("rst_misaligned", {31'b0, misal}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      rst = 1'b0;

      // Byte load, sign-extended from bit 7.
      preset(A, 32'h1122_33F4);
      issue(1'b0, 2'b00, 1'b1, A + 3, 32'h0, K_LOAD, 32'hFFFF_FFF4);
      drain();

      // Half loads, lower half in big-endian order.
      preset(A, 32'h1122_F344);
      issue(1'b0, 2'b01, 1'b0, A + 2, 32'h0, K_LOAD, 32'h0000_F344);
      issue(1'b0, 2'b01, 1'b1, A + 2, 32'h0, K_LOAD, 32'hFFFF_F344);
      drain();
      check("load_data_held", load_data, 32'hFFFF_F344);

      // Byte store via read-modify-write, then read back.
      preset(A, 32'h1122_3344);
      issue(1'b1, 2'b00, 1'b0, A + 1, 32'h0000_00AB, K_SST, 32'h11AB_3344);
      drain();
      check("mem_after_sb", mem[idx(A)], 32'h11AB_3344);
      issue(1'b0, 2'b11, 1'b0, A, 32'h0, K_LOAD, 32'h11AB_3344);
      issue(1'b0, 2'b00, 1'b0, A, 32'h0, K_LOAD, 32'h0000_0011);
      drain();

      // Half store: only low 16 bits of store data may be used.
      issue(1'b1, 2'b01, 1'b0, A + 2, 32'hFFFF_5678, K_SST, 32'h11AB_5678);
      drain();
      check("mem_after_sh", mem[idx(A)], 32'h11AB_5678);

      // Word store at the top word: write strobe only.
      issue(1'b1, 2'b11, 1'b0, B, 32'hDEAD_BEEF, K_WST, 32'h0);
      drain();
      check("mem_after_sw", mem[idx(B)], 32'hDEAD_BEEF);

      // Size 2'b10 is treated as a word.
      issue(1'b0, 2'b10, 1'b0, B, 32'h0, K_LOAD, 32'hDEAD_BEEF);
      drain();

      // Misaligned half at A+1.
`ifdef MISALIGN_TRAP_EN
      issue(1'b0, 2'b01, 1'b0, A + 1, 32'h0, K_MIS, 32'h0);
`else
      issue(1'b0, 2'b01, 1'b0, A + 1, 32'h0, K_LOAD, 32'h0000_11AB);
`endif
      drain();

      // Reset while a byte store is in its read cycle: the write must never happen.
      issue(1'b1, 2'b00, 1'b0, A, 32'h0000_0000, K_RDONLY, 32'h0);
      check("busy_in_rd", {31'b0, busy}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("busy_after_reset", {31'b0, busy}, 32'h0);
      drain();
      check("mem_after_abort", mem[idx(A)], 32'h11AB_5678);

      // A request presented while busy is ignored.
      issue(1'b0, 2'b11, 1'b0, B, 32'h0, K_LOAD, 32'hDEAD_BEEF);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_addr = A; req_wdata = 32'h0;
      @(negedge clk);
      req_valid = 1'b0;
      drain();
      check("mem_after_ignored", mem[idx(A)], 32'h11AB_5678);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
